// File: rtl/rtc_pkg.sv
// Shared widths, limits, time record and rollover helpers for the RTC block.
package rtc_pkg;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } rtc_time_t;

  // Time one second later, with sec/min/hour cascade wrapping.
  function automatic rtc_time_t time_inc(input rtc_time_t t, input int hour_max);
    rtc_time_t n;
    n = t;
    if (t.sec == SEC_W'(SEC_MAX)) begin
      n.sec = '0;
      if (t.min == MIN_W'(MIN_MAX)) begin
        n.min = '0;
        if (int'(t.hour) >= hour_max - 1) n.hour = '0;
        else                              n.hour = t.hour + 1'b1;
      end else begin
        n.min = t.min + 1'b1;
      end
    end else begin
      n.sec = t.sec + 1'b1;
    end
    return n;
  endfunction

  // Out-of-range preset fields are replaced by zero, each field independently.
  function automatic rtc_time_t load_clip(input rtc_time_t raw, input int hour_max);
    rtc_time_t c;
    c.hour = (int'(raw.hour) >= hour_max) ? '0 : raw.hour;
    c.min  = (raw.min > MIN_W'(MIN_MAX))  ? '0 : raw.min;
    c.sec  = (raw.sec > SEC_W'(SEC_MAX))  ? '0 : raw.sec;
    return c;
  endfunction
endpackage

// File: rtl/rtc_counter_if.sv
// Control/preset/time bundle of the RTC; alarm signals exist only with RTC_ALARM_EN.
interface rtc_counter_if;
  import rtc_pkg::*;

  logic              run;
  logic              load;
  logic [HOUR_W-1:0] load_hour;
  logic [MIN_W-1:0]  load_min;
  logic [SEC_W-1:0]  load_sec;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  min;
  logic [SEC_W-1:0]  sec;
  logic              pps;
  logic              min_tick;
  logic              hour_tick;
`ifdef RTC_ALARM_EN
  logic              alarm_en;
  logic [HOUR_W-1:0] alarm_hour;
  logic [MIN_W-1:0]  alarm_min;
  logic [SEC_W-1:0]  alarm_sec;
  logic              alarm;

  modport master (output run, load, load_hour, load_min, load_sec,
                  output alarm_en, alarm_hour, alarm_min, alarm_sec,
                  input  hour, min, sec, pps, min_tick, hour_tick, alarm);
  modport slave  (input  run, load, load_hour, load_min, load_sec,
                  input  alarm_en, alarm_hour, alarm_min, alarm_sec,
                  output hour, min, sec, pps, min_tick, hour_tick, alarm);
`else
  modport master (output run, load, load_hour, load_min, load_sec,
                  input  hour, min, sec, pps, min_tick, hour_tick);
  modport slave  (input  run, load, load_hour, load_min, load_sec,
                  output hour, min, sec, pps, min_tick, hour_tick);
`endif
endinterface

// File: rtl/rtc_prescaler.sv
// Seconds divider (0..CLK_DIV-1) producing a one-cycle tick, plus the pps stretcher.
module rtc_prescaler #(
  parameter int unsigned CLK_DIV   = 50_000_000,
  parameter int unsigned PPS_WIDTH = 1
) (
  input  logic clk_50m,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick,
  output logic pps
);
  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int PPS_CNT_W = $clog2(PPS_WIDTH + 1);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PPS_CNT_W-1:0] PPS_LAST = PPS_CNT_W'(PPS_WIDTH - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [PPS_CNT_W-1:0] pps_cnt;

  assign tick = run && !clear && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // pps_cnt holds the remaining high cycles after the current one; run does not gate it.
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      pps     <= 1'b0;
      pps_cnt <= '0;
    end else if (tick) begin
      pps     <= 1'b1;
      pps_cnt <= PPS_LAST;
    end else if (pps_cnt != '0) begin
      pps_cnt <= pps_cnt - 1'b1;
    end else begin
      pps     <= 1'b0;
    end
  end
endmodule

// File: rtl/rtc_counter.sv
// Real-time clock hh:mm:ss with preset, pps and rollover pulses.
// Optional alarm compare is built when RTC_ALARM_EN is defined.
module rtc_counter
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50_000_000,
  parameter int unsigned PPS_WIDTH = 1,
  parameter int unsigned HOUR_MAX  = 24
) (
  input  logic          clk_50m,
  input  logic          reset,
  rtc_counter_if.slave  bus
);
  logic      tick;
  logic      pps;
  logic      min_tick;
  logic      hour_tick;
  rtc_time_t cur_time;
  rtc_time_t next_time;
  rtc_time_t load_time;

  rtc_prescaler #(
    .CLK_DIV   (CLK_DIV),
    .PPS_WIDTH (PPS_WIDTH)
  ) u_prescaler (
    .clk_50m (clk_50m),
    .reset   (reset),
    .run     (bus.run),
    .clear   (bus.load),
    .tick    (tick),
    .pps     (pps)
  );

  assign next_time = time_inc(cur_time, int'(HOUR_MAX));
  assign load_time = load_clip({bus.load_hour, bus.load_min, bus.load_sec}, int'(HOUR_MAX));

  // tick is already masked by load inside the prescaler, but load must win here too.
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      cur_time  <= '0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
    end else if (bus.load) begin
      cur_time  <= load_time;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
    end else if (tick) begin
      cur_time  <= next_time;
      min_tick  <= (cur_time.sec == SEC_W'(SEC_MAX));
      hour_tick <= (cur_time.sec == SEC_W'(SEC_MAX)) && (cur_time.min == MIN_W'(MIN_MAX));
    end else begin
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
    end
  end

  assign bus.hour      = cur_time.hour;
  assign bus.min       = cur_time.min;
  assign bus.sec       = cur_time.sec;
  assign bus.pps       = pps;
  assign bus.min_tick  = min_tick;
  assign bus.hour_tick = hour_tick;

`ifdef RTC_ALARM_EN
  logic alarm;

  // Matches only on the time reached by a tick, so a preset never fires the alarm.
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) alarm <= 1'b0;
    else       alarm <= tick && bus.alarm_en &&
                        (next_time == {bus.alarm_hour, bus.alarm_min, bus.alarm_sec});
  end

  assign bus.alarm = alarm;
`endif
endmodule

// File: tb/tb_rtc_counter.sv
// Directed scoreboard bench for rtc_counter (CLK_DIV=10, PPS_WIDTH=3, HOUR_MAX=24).
module tb_rtc_counter;
  logic clk_50m = 1'b0;
  logic reset;

  always #5 clk_50m = ~clk_50m;

  rtc_counter_if bus ();

  rtc_counter #(
    .CLK_DIV   (10),
    .PPS_WIDTH (3),
    .HOUR_MAX  (24)
  ) dut (
    .clk_50m (clk_50m),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    return 32'(h * 10000 + m * 100 + s);
  endfunction

  function automatic logic [31:0] now();
    return hms(int'(bus.hour), int'(bus.min), int'(bus.sec));
  endfunction

  task automatic do_load(input int h, input int m, input int s);
    bus.load_hour = 5'(h);
    bus.load_min  = 6'(m);
    bus.load_sec  = 6'(s);
    bus.load      = 1'b1;
    step(1);
    bus.load      = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.run       = 1'b1;
    bus.load      = 1'b0;
    bus.load_hour = '0;
    bus.load_min  = '0;
    bus.load_sec  = '0;
`ifdef RTC_ALARM_EN
    bus.alarm_en   = 1'b0;
    bus.alarm_hour = '0;
    bus.alarm_min  = '0;
    bus.alarm_sec  = 6'd3;
`endif
    step(3);
    expect_val("rst_time", hms(0, 0, 0));      check(now());
    expect_val("rst_pps", 0);                  check(32'(bus.pps));
    expect_val("rst_min_tick", 0);             check(32'(bus.min_tick));
    expect_val("rst_hour_tick", 0);            check(32'(bus.hour_tick));
    reset = 1'b0;

    // First tick on the 10th edge after release.
    step(9);
    expect_val("pre_first_tick", hms(0, 0, 0)); check(now());
    expect_val("pps_pre", 0);                   check(32'(bus.pps));
    step(1);
    expect_val("sec_cycle11", hms(0, 0, 1));    check(now());
    expect_val("pps_cycle11", 1);               check(32'(bus.pps));
    step(2);
    expect_val("pps_cycle13", 1);               check(32'(bus.pps));
    step(1);
    expect_val("pps_cycle14", 0);               check(32'(bus.pps));
    step(37);
    expect_val("sec_after51", hms(0, 0, 5));    check(now());

    // Day rollover.
    do_load(23, 59, 58);
    expect_val("load_235958", hms(23, 59, 58)); check(now());
    step(10);
    expect_val("t_235959", hms(23, 59, 59));    check(now());
    expect_val("min_tick_idle", 0);             check(32'(bus.min_tick));
    step(10);
    expect_val("t_000000", hms(0, 0, 0));       check(now());
    expect_val("min_tick_wrap", 1);             check(32'(bus.min_tick));
    expect_val("hour_tick_wrap", 1);            check(32'(bus.hour_tick));
    expect_val("pps_wrap", 1);                  check(32'(bus.pps));
    step(1);
    expect_val("min_tick_1cyc", 0);             check(32'(bus.min_tick));
    expect_val("hour_tick_1cyc", 0);            check(32'(bus.hour_tick));

    // Load landing on divider terminal count suppresses the tick.
    step(8);
    do_load(1, 2, 3);
    expect_val("load_on_tc", hms(1, 2, 3));     check(now());
    expect_val("load_no_pps", 0);               check(32'(bus.pps));
    expect_val("load_no_min_tick", 0);          check(32'(bus.min_tick));
    step(9);
    expect_val("no_early_tick", hms(1, 2, 3));  check(now());
    step(1);
    expect_val("tick_after_load", hms(1, 2, 4)); check(now());
    expect_val("pps_after_load", 1);            check(32'(bus.pps));

    // Freeze mid-count while a pps pulse is in flight.
    step(1);
    bus.run = 1'b0;
    step(1);
    expect_val("pps_completes", 1);             check(32'(bus.pps));
    step(24);
    expect_val("pps_done_frozen", 0);           check(32'(bus.pps));
    expect_val("time_frozen", hms(1, 2, 4));    check(now());
    bus.run = 1'b1;
    step(8);
    expect_val("resume_no_tick", hms(1, 2, 4)); check(now());
    step(1);
    expect_val("resume_tick", hms(1, 2, 5));    check(now());

    // Out-of-range presets, loaded while run=0.
    bus.run = 1'b0;
    do_load(30, 12, 60);
    expect_val("clip_hour_sec", hms(0, 12, 0)); check(now());
    do_load(23, 60, 59);
    expect_val("clip_min", hms(23, 0, 59));     check(now());
    bus.run = 1'b1;
    step(10);
    expect_val("minute_roll", hms(23, 1, 0));   check(now());
    expect_val("min_tick_only", 1);             check(32'(bus.min_tick));
    expect_val("hour_tick_quiet", 0);           check(32'(bus.hour_tick));

    // Asynchronous reset in the middle of a pps pulse.
    step(1);
    reset = 1'b1;
    #1;
    expect_val("rst_async_pps", 0);             check(32'(bus.pps));
    expect_val("rst_async_time", hms(0, 0, 0)); check(now());
`ifdef RTC_ALARM_EN
    bus.alarm_en = 1'b1;
    expect_val("rst_alarm", 0);                 check(32'(bus.alarm));
`endif
    step(2);
    reset = 1'b0;

`ifdef RTC_ALARM_EN
    step(29);
    expect_val("alarm_before", 0);              check(32'(bus.alarm));
    expect_val("alarm_t2", hms(0, 0, 2));       check(now());
    step(1);
    expect_val("alarm_hit", 1);                 check(32'(bus.alarm));
    expect_val("alarm_t3", hms(0, 0, 3));       check(now());
    step(1);
    expect_val("alarm_1cyc", 0);                check(32'(bus.alarm));
    do_load(0, 0, 3);
    expect_val("alarm_not_load", 0);            check(32'(bus.alarm));
    bus.alarm_en = 1'b0;
    do_load(0, 0, 2);
    step(10);
    expect_val("alarm_dis_t3", hms(0, 0, 3));   check(now());
    expect_val("alarm_disabled", 0);            check(32'(bus.alarm));
`else
    step(10);
    expect_val("post_rst_tick", hms(0, 0, 1));  check(now());
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
